// File: rtl/sqrt_sched_pkg.sv
// Shared definitions for sqrt_req_scheduler: FSM state encoding and default watchdog limit.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } sched_state_e;

    localparam int unsigned DefaultTimeoutCycles = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_valid
);

    logic [ID_WIDTH-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_WIDTH'((32'(ptr) + i) % NUM_REQ);
            if (en && !grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_req_scheduler.sv
// Shares one start/done sqrt engine between NUM_REQ requesters, one job in flight at a time.
// Optional engine watchdog enabled by defining SQRT_REQ_SCHED_TIMEOUT_EN.
module sqrt_req_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_radicand,
    input  logic                          eng_done,
    input  logic [DATA_WIDTH-1:0]         eng_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } rsp_t;

    sched_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] radicand_q, radicand_d;
    rsp_t                  rsp_q, rsp_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_valid;
    logic                  arb_en;
    logic [DATA_WIDTH-1:0] granted_data;
    logic                  expired;

    // Gating on rst keeps req_ready low while reset is asserted.
    assign arb_en = (state_q == StIdle) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .en         (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always_comb begin
        granted_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) granted_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SQRT_REQ_SCHED_TIMEOUT_EN
    localparam int unsigned TimerWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TimerWidth-1:0] timer_q, timer_d;

    assign expired = (32'(timer_q) == TIMEOUT_CYCLES - 1);

    always_comb begin
        timer_d = timer_q;
        if (state_q == StIssue) begin
            timer_d = '0;
        end else if (state_q == StWait && !expired) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        radicand_d = radicand_q;
        rsp_d      = rsp_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    radicand_d = granted_data;
                    rsp_d.id   = grant_idx;
                    rr_ptr_d   = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // A done landing on the expiry cycle takes priority over the watchdog.
                if (eng_done) begin
                    rsp_d.data = eng_result;
                    rsp_d.err  = 1'b0;
                    state_d    = StResp;
                end else if (expired) begin
                    rsp_d.data = '0;
                    rsp_d.err  = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            radicand_q <= '0;
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            radicand_q <= radicand_d;
            rsp_q      <= rsp_d;
        end
    end

    assign req_ready    = grant;
    assign eng_start    = (state_q == StIssue);
    assign eng_radicand = radicand_q;
    assign rsp_valid    = (state_q == StResp);
    assign rsp_id       = rsp_q.id;
    assign rsp_data     = rsp_q.data;
    assign rsp_err      = rsp_q.err;

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Randomised scoreboard bench for sqrt_req_scheduler with a behavioural engine and arbiter model.
module tb_sqrt_req_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int IDW     = 2;
    localparam int TO      = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*DW-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  eng_start;
    logic [DW-1:0]         eng_radicand;
    logic                  eng_done = 1'b0;
    logic [DW-1:0]         eng_result = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_err;

    always #5 clk = ~clk;

    sqrt_req_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .DATA_WIDTH    (DW),
        .ID_WIDTH      (IDW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .eng_start   (eng_start),
        .eng_radicand(eng_radicand),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    typedef struct {
        int          id;
        int unsigned data;
        bit          err;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    int unsigned jobq[NUM_REQ][$];
    int          grant_log[$];
    int          n_grants = 0;
    int          mrr = 0;
    bit          outstanding = 1'b0;
    int          grant_cyc = -100;
    int          free_cyc = 0;
    int unsigned exp_rad = 0;
    bit          eng_hang = 1'b0;
    int          lat_min = 1;
    int          lat_max = 6;
    int          valid_pct = 100;
    int          rdy_pct = 100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned isqrt(int unsigned x);
        longint unsigned r = 0;
        longint unsigned t;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= 64'(x)) r = t;
        end
        return int'(r);
    endfunction

    function automatic int model_pick(logic [NUM_REQ-1:0] v, int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < NUM_REQ; i++) if (jobq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string name, longint got, longint expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Requester driver: inputs change 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (jobq[i].size() > 0 && int'($urandom_range(99)) < valid_pct) begin
                    req_valid[i]            = 1'b1;
                    req_data[i*DW +: DW]    = jobq[i][0];
                end else begin
                    req_valid[i]            = 1'b0;
                    req_data[i*DW +: DW]    = $urandom;
                end
            end
            rsp_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    // Behavioural sqrt engine with programmable latency; garbage on eng_result when not done.
    initial begin
        bit          busy = 1'b0;
        int          cnt = 0;
        int unsigned val = 0;
        forever begin
            @(negedge clk);
            if (eng_start && !rst) begin
                busy = !eng_hang;
                val  = isqrt(eng_radicand);
                cnt  = int'($urandom_range(lat_max, lat_min));
            end
            @(posedge clk);
            #1;
            eng_done   = 1'b0;
            eng_result = $urandom;
            if (busy) begin
                if (cnt <= 1) begin
                    eng_done   = 1'b1;
                    eng_result = val;
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Grant side: check the arbiter choice and push the expected response.
    always @(negedge clk) begin
        int          g;
        int unsigned job;
        exp_t        e;
        if (!rst) begin
            if (req_ready != '0) begin
                g = model_pick(req_valid, mrr);
                chk("grant_idx", onehot_idx(req_ready), g);
                chk("grant_onehot", $countones(req_ready), 1);
                chk("grant_while_busy", (outstanding || cyc < free_cyc) ? 1 : 0, 0);
                if (g >= 0 && jobq[g].size() > 0) begin
                    job  = jobq[g].pop_front();
                    e.id = g;
`ifdef SQRT_REQ_SCHED_TIMEOUT_EN
                    e.data = eng_hang ? 0 : isqrt(job);
                    e.err  = eng_hang;
`else
                    e.data = isqrt(job);
                    e.err  = 1'b0;
`endif
                    exp_q.push_back(e);
                    exp_rad = job;
                    grant_log.push_back(g);
                    n_grants++;
                    mrr = (g + 1) % NUM_REQ;
                end
                grant_cyc   = cyc;
                outstanding = 1'b1;
            end else if (req_valid != '0 && !outstanding && cyc >= free_cyc) begin
                chk("grant_missing", 0, 1);
            end
        end
    end

    // Response monitor: engine start timing, response timing, stability and scoreboard compare.
    bit          hold_prev = 1'b0;
    bit          done_prev = 1'b0;
    logic [IDW-1:0] sv_id;
    logic [DW-1:0]  sv_data;
    logic           sv_err;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (eng_start) begin
                chk("start_after_grant", cyc - grant_cyc, 1);
                chk("start_radicand", eng_radicand, exp_rad);
            end
            if (done_prev && outstanding) chk("rsp_after_done", rsp_valid, 1);
            if (rsp_valid && !outstanding) chk("rsp_without_job", 1, 0);
            if (rsp_valid && hold_prev) begin
                chk("hold_id", rsp_id, sv_id);
                chk("hold_data", rsp_data, sv_data);
                chk("hold_err", rsp_err, sv_err);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                end
                outstanding = 1'b0;
                free_cyc    = cyc + 1;
            end
            hold_prev = rsp_valid && !rsp_ready;
            sv_id     = rsp_id;
            sv_data   = rsp_data;
            sv_err    = rsp_err;
            done_prev = eng_done;
        end else begin
            hold_prev = 1'b0;
            done_prev = 1'b0;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) jobq[i].delete();
        outstanding = 1'b0;
        mrr         = 0;
        free_cyc    = 0;
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_eng_radicand"}, eng_radicand, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (n < budget && !(queues_empty() && exp_q.size() == 0 && !outstanding)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({name, "_drain_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_start(string name, output int at);
        int n = 0;
        at = -1;
        while (n < 100 && at < 0) begin
            @(negedge clk);
            if (eng_start) at = cyc;
            n++;
        end
        if (at < 0) chk({name, "_no_start"}, 0, 1);
    endtask

    initial begin
        int st;
        int seen;
        int n;
        int unsigned x;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request
        lat_min = 5; lat_max = 5;
        jobq[0].push_back(144);
        wait_drain("single", 200);
        chk("single_grants", n_grants, 1);

        // Fairness from rr_ptr=0
        do_reset();
        lat_min = 2; lat_max = 4;
        grant_log.delete();
        jobq[0].push_back(1);
        jobq[0].push_back(25);
        jobq[1].push_back(4);
        jobq[2].push_back(9);
        jobq[3].push_back(16);
        wait_drain("fair", 300);
        chk("fair_count", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            chk("fair_order0", grant_log[0], 0);
            chk("fair_order1", grant_log[1], 1);
            chk("fair_order2", grant_log[2], 2);
            chk("fair_order3", grant_log[3], 3);
            chk("fair_order4", grant_log[4], 0);
        end

        // Backpressure with requests pending
        rdy_pct = 0;
        jobq[1].push_back(49);
        jobq[2].push_back(64);
        seen = 0;
        n = 0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            seen = rsp_valid;
            n++;
        end
        chk("bp_rsp_seen", seen, 1);
        repeat (10) @(negedge clk);
        chk("bp_still_valid", rsp_valid, 1);
        rdy_pct = 100;
        wait_drain("bp", 300);

        // Wrap and skip: rr_ptr driven to 3, then req 0 and 2 pending
        do_reset();
        jobq[2].push_back(81);
        wait_drain("wrap_prep", 200);
        grant_log.delete();
        jobq[0].push_back(100);
        jobq[2].push_back(121);
        wait_drain("wrap", 200);
        chk("wrap_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("wrap_first", grant_log[0], 0);
            chk("wrap_second", grant_log[1], 2);
        end

        // Reset in WAIT; the late eng_done must be ignored
        lat_min = 20; lat_max = 20;
        jobq[3].push_back(400);
        wait_start("midwait", st);
        repeat (3) @(negedge clk);
        do_reset();
        @(negedge clk);
        check_zero_outputs("midwait");
        lat_min = 1; lat_max = 6;
        repeat (25) @(negedge clk);
        grant_log.delete();
        jobq[1].push_back(36);
        wait_drain("after_reset", 200);
        chk("after_reset_count", grant_log.size(), 1);
        if (grant_log.size() == 1) chk("after_reset_grant", grant_log[0], 1);

        // Engine that never answers
        eng_hang = 1'b1;
        jobq[2].push_back(900);
        wait_start("hang", st);
`ifdef SQRT_REQ_SCHED_TIMEOUT_EN
        seen = 0;
        n = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
            n++;
        end
        chk("timeout_seen", seen, 1);
        chk("timeout_latency", cyc - st, TO + 1);
        wait_drain("timeout", 100);
        eng_hang = 1'b0;
`else
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("wait_forever", seen, 0);
        eng_hang = 1'b0;
        do_reset();
`endif

        // Randomised traffic with dropouts, backpressure and variable engine latency
        valid_pct = 70;
        rdy_pct   = 60;
        lat_min   = 1;
        lat_max   = 6;
        for (int j = 0; j < 80; j++) begin
            if ($urandom_range(1) == 1) begin
                x = $urandom;
            end else begin
                x = $urandom_range(65535);
                x = x * x;
            end
            jobq[$urandom_range(NUM_REQ - 1)].push_back(x);
        end
        wait_drain("random", 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
